// File: rtl/cache_block_fetcher_pkg.sv
// Shared types, constants and the byte-lane mapping for the cache block fetcher.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, DONE} fetch_state_t;

    localparam int BLOCK_BYTES       = 16;
    localparam int WORDS_PER_BLOCK   = 4;
    localparam int WORD_OFFSET_BITS  = 2;
    localparam int BLOCK_OFFSET_BITS = 4;

    // Memory words are big-endian (lowest address in [31:24]) while the block
    // keeps byte k at [8k+7:8k], so each word is byte-reversed into its lane.
    function automatic logic [127:0] place_word(input logic [1:0]  idx,
                                                input logic [31:0] word);
        logic [127:0] lanes;
        lanes = {96'b0, word[7:0], word[15:8], word[23:16], word[31:24]};
        return lanes << {idx, 5'b0};
    endfunction

endpackage

// File: rtl/cache_block_fetcher_block_assembler.sv
// 128-bit block buffer with a per-word write port and a synchronous clear.
module block_assembler
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [1:0]   idx,
    input  logic [31:0]  wdata,
    output logic [127:0] block
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block <= '0;
        end else if (clr) begin
            block <= '0;
        end else if (we) begin
            block <= (block & ~place_word(idx, 32'hFFFF_FFFF)) | place_word(idx, wdata);
        end
    end

endmodule

// File: rtl/cache_block_fetcher.sv
// Cache miss block fetcher: four word reads, assemble, load into the cache array.
// Optional CRITICAL_WORD_FIRST_EN starts at the missed word and reports it early.
module cache_block_fetcher
    import cache_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int CACHE_ADDR_WIDTH = 9,
    parameter int DATA_WIDTH       = 32
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss_req,
    input  logic [MEM_ADDR_WIDTH-1:0]   miss_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    input  logic                        mem_ready,
    output logic                        load_block,
    output logic [CACHE_ADDR_WIDTH-1:0] cache_addr,
    output logic [127:0]                block_out,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic                        crit_valid,
    output logic [DATA_WIDTH-1:0]       crit_word,
`endif
    input  logic                        finish_writing_block
);

    fetch_state_t state, state_nx;
    logic [MEM_ADDR_WIDTH-1:0]   base;
    logic [WORD_OFFSET_BITS-1:0] k;
    logic [WORD_OFFSET_BITS-1:0] word_idx;
    logic accept, word_we, last_word;

    assign accept    = (state == IDLE) && miss_req;
    assign word_we   = (state == FETCH) && mem_ready;
    assign last_word = (k == WORD_OFFSET_BITS'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // k counts words fetched; word_idx is the block word currently requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
            k    <= '0;
        end else if (accept) begin
            base <= miss_addr & ~MEM_ADDR_WIDTH'(BLOCK_BYTES - 1);
            k    <= '0;
        end else if (word_we) begin
            k <= k + 1'b1;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    logic [WORD_OFFSET_BITS-1:0] w0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0         <= '0;
            crit_valid <= 1'b0;
            crit_word  <= '0;
        end else begin
            if (accept) w0 <= miss_addr[BLOCK_OFFSET_BITS-1:WORD_OFFSET_BITS];
            crit_valid <= word_we && (k == '0);
            if (word_we && (k == '0)) crit_word <= mem_rdata;
        end
    end

    assign word_idx = w0 + k;
`else
    assign word_idx = k;
`endif

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        load_block = 1'b0;
        case (state)
            IDLE: begin
                if (miss_req) state_nx = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = base + MEM_ADDR_WIDTH'({word_idx, {WORD_OFFSET_BITS{1'b0}}});
                if (mem_ready && last_word) state_nx = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                load_block = 1'b1;
                if (finish_writing_block) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cache_addr = base[CACHE_ADDR_WIDTH-1:0];

    block_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .we    (word_we),
        .idx   (word_idx),
        .wdata (mem_rdata),
        .block (block_out)
    );

endmodule

// File: tb/tb_cache_block_fetcher.sv
// Directed bench for cache_block_fetcher with memory and cache-array responders.
// Handshake: a word is taken on an edge where mem_rd && mem_ready; a block is taken on an edge where load_block && finish_writing_block.
module tb_cache_block_fetcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_req;
    logic [9:0]   miss_addr;
    logic         busy, done, mem_rd, load_block;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
    logic [8:0]   cache_addr;
    logic [127:0] block_out;
    logic         finish_writing_block;
`ifdef CRITICAL_WORD_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_word;
`endif

    cache_block_fetcher dut (
        .clk                  (clk),
        .rst                  (rst),
        .miss_req             (miss_req),
        .miss_addr            (miss_addr),
        .busy                 (busy),
        .done                 (done),
        .mem_rd               (mem_rd),
        .mem_addr             (mem_addr),
        .mem_rdata            (mem_rdata),
        .mem_ready            (mem_ready),
        .load_block           (load_block),
        .cache_addr           (cache_addr),
        .block_out            (block_out),
`ifdef CRITICAL_WORD_FIRST_EN
        .crit_valid           (crit_valid),
        .crit_word            (crit_word),
`endif
        .finish_writing_block (finish_writing_block)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    localparam logic [127:0] BLK_1A0 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] BLK_040 = 128'h100F0E0D_0C0B0A09_08070605_04030201;

    logic [31:0] mem [256];
    logic [9:0]  exp_q[$];
    logic [9:0]  acc_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int mem_wait = 0;
    int ack_wait = 1;
    int addr_unstable = 0;
    int blk_unstable  = 0;
    int done_cnt = 0;
    int load_cnt = 0;
    int crit_cnt = 0;
    logic [31:0] crit_seen = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_order(input string tag);
        check({tag, "_count"}, 128'(acc_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 128'(acc_q[i]), 128'(exp_q[i]));
    endtask

    // ---------------- memory responder: ready on cycle mem_wait+1 of each word ----------------
    always @(posedge clk) begin
        int   wcnt;
        logic [9:0] last_addr;
        #1;
        if (rst || !mem_rd) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (wcnt > 0 && mem_addr != last_addr) addr_unstable++;
            last_addr = mem_addr;
            if (wcnt >= mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                acc_q.push_back(mem_addr);
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end
    end

    // ---------------- cache array responder and output monitor ----------------
    always @(posedge clk) begin
        int   lcnt;
        logic [127:0] last_blk;
        #1;
        if (load_block) begin
            if (lcnt > 0 && block_out != last_blk) blk_unstable++;
            last_blk = block_out;
            load_cnt++;
            finish_writing_block = (lcnt >= ack_wait);
            lcnt++;
        end else begin
            finish_writing_block = 1'b0;
            lcnt = 0;
        end
        if (done) done_cnt++;
`ifdef CRITICAL_WORD_FIRST_EN
        if (crit_valid) begin
            crit_cnt++;
            crit_seen = crit_word;
        end
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counters();
        acc_q.delete();
        exp_q.delete();
        addr_unstable = 0;
        blk_unstable  = 0;
        done_cnt = 0;
        load_cnt = 0;
        crit_cnt = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int t0, output int lat);
        int n = 0;
        while (!done && n < 300) begin
            cycle();
            n++;
        end
        if (!done) check({tag, "_timeout"}, 128'(0), 128'(1));
        lat = cyc - t0;
        miss_req = 1'b0;
    endtask

    task automatic run_miss(input string tag, input logic [9:0] addr, output int lat);
        int t0;
        miss_req  = 1'b1;
        miss_addr = addr;
        t0 = cyc;
        wait_done(tag, t0, lat);
        repeat (3) cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        mem[8'h68] = 32'h0011_2233;
        mem[8'h69] = 32'h4455_6677;
        mem[8'h6A] = 32'h8899_AABB;
        mem[8'h6B] = 32'hCCDD_EEFF;
        mem[8'h10] = 32'h0102_0304;
        mem[8'h11] = 32'h0506_0708;
        mem[8'h12] = 32'h090A_0B0C;
        mem[8'h13] = 32'h0D0E_0F10;

        rst = 1'b1;
        miss_req = 1'b0;
        miss_addr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        finish_writing_block = 1'b0;
        repeat (2) cycle();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_mem_rd", 128'(mem_rd), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_load_block", 128'(load_block), 128'(0));
        check("rst_cache_addr", 128'(cache_addr), 128'(0));
        check("rst_block_out", block_out, 128'(0));
        rst = 1'b0;
        repeat (2) cycle();

        // Test 1: back-to-back memory, ack one cycle after load_block
        clear_counters();
        mem_wait = 0;
        ack_wait = 1;
`ifdef CRITICAL_WORD_FIRST_EN
        exp_q = '{10'h1A4, 10'h1A8, 10'h1AC, 10'h1A0};
`else
        exp_q = '{10'h1A0, 10'h1A4, 10'h1A8, 10'h1AC};
`endif
        run_miss("t1", 10'h1A7, lat);
        check("t1_latency", 128'(lat), 128'(7));
        check_order("t1");
        check("t1_block", block_out, BLK_1A0);
        check("t1_byte0", 128'(block_out[7:0]), 128'(8'h00));
        check("t1_byte15", 128'(block_out[127:120]), 128'(8'hFF));
        check("t1_cache_addr", 128'(cache_addr), 128'(9'h1A0));
        check("t1_done_cnt", 128'(done_cnt), 128'(1));
        check("t1_load_cycles", 128'(load_cnt), 128'(2));
        check("t1_idle_busy", 128'(busy), 128'(0));

        // Test 2: memory ready on the third cycle of every word
        clear_counters();
        mem_wait = 2;
        exp_q = '{10'h1A0, 10'h1A4, 10'h1A8, 10'h1AC};
        run_miss("t2", 10'h1A0, lat);
        check("t2_latency", 128'(lat), 128'(15));
        check("t2_addr_stable", 128'(addr_unstable), 128'(0));
        check_order("t2");
        check("t2_block", block_out, BLK_1A0);
        check("t2_done_cnt", 128'(done_cnt), 128'(1));

        // Test 3: cache withholds the acknowledge for 5 cycles
        clear_counters();
        mem_wait = 0;
        ack_wait = 5;
        run_miss("t3", 10'h1AF, lat);
        check("t3_latency", 128'(lat), 128'(11));
        check("t3_load_cycles", 128'(load_cnt), 128'(6));
        check("t3_block_stable", 128'(blk_unstable), 128'(0));
        check("t3_block", block_out, BLK_1A0);
        check("t3_done_cnt", 128'(done_cnt), 128'(1));
        ack_wait = 1;

        // Test 4: a second miss_req pulse during FETCH is ignored
        clear_counters();
        exp_q = '{10'h1A0, 10'h1A4, 10'h1A8, 10'h1AC};
        begin
            int t0;
            miss_req  = 1'b1;
            miss_addr = 10'h1A3;
            t0 = cyc;
            cycle();
            check("t4_in_fetch", 128'(mem_rd), 128'(1));
            miss_req = 1'b0;
            cycle();
            miss_req  = 1'b1;
            miss_addr = 10'h040;
            cycle();
            miss_req = 1'b0;
            wait_done("t4", t0, lat);
            repeat (6) cycle();
        end
        check_order("t4");
        check("t4_block", block_out, BLK_1A0);
        check("t4_cache_addr", 128'(cache_addr), 128'(9'h1A0));
        check("t4_done_cnt", 128'(done_cnt), 128'(1));

        // Test 5: reset while word 2 is being fetched
        clear_counters();
        miss_req  = 1'b1;
        miss_addr = 10'h1A0;
        repeat (3) cycle();
        check("t5_pre_addr", 128'(mem_addr), 128'(10'h1A8));
        rst = 1'b1;
        miss_req = 1'b0;
        #1;
        check("t5_rst_busy", 128'(busy), 128'(0));
        check("t5_rst_mem_rd", 128'(mem_rd), 128'(0));
        check("t5_rst_mem_addr", 128'(mem_addr), 128'(0));
        check("t5_rst_load", 128'(load_block), 128'(0));
        check("t5_rst_block", block_out, 128'(0));
        check("t5_rst_cache_addr", 128'(cache_addr), 128'(0));
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        check("t5_no_done", 128'(done_cnt), 128'(0));
        clear_counters();
        exp_q = '{10'h040, 10'h044, 10'h048, 10'h04C};
        run_miss("t5", 10'h040, lat);
        check("t5_latency", 128'(lat), 128'(7));
        check_order("t5");
        check("t5_block", block_out, BLK_040);
        check("t5_cache_addr", 128'(cache_addr), 128'(9'h040));
        check("t5_done_cnt", 128'(done_cnt), 128'(1));

`ifdef CRITICAL_WORD_FIRST_EN
        // Test 6: critical word first from word 2
        clear_counters();
        exp_q = '{10'h1A8, 10'h1AC, 10'h1A0, 10'h1A4};
        run_miss("t6", 10'h1A8, lat);
        check_order("t6");
        check("t6_crit_word", 128'(crit_seen), 128'(32'h8899_AABB));
        check("t6_crit_cnt", 128'(crit_cnt), 128'(1));
        check("t6_block", block_out, BLK_1A0);
        check("t6_latency", 128'(lat), 128'(7));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
